// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receive path (8N1 by default), counterpart of the transmit FSM.
// The asynchronous serial line is brought into the clk_50M domain through a
// two-flop synchroniser, oversampled on a tick strobe running at
// OVERSAMPLE x baud, and framed as start / DATA_BITS data (LSB first) / stop.
// A good frame updates rx_data and pulses rx_valid for one clock; a frame
// whose stop bit samples low pulses frame_err instead and leaves rx_data
// untouched.
//
// Parameters
//   DATA_BITS   data bits per frame, LSB first, no parity (default 8)
//   OVERSAMPLE  tick_16x pulses per bit period, even and >= 4 (default 16)
//
// Ports
//   clk_50M    in   system clock
//   rst_n      in   synchronous active-low reset
//   tick_16x   in   one-cycle strobe at OVERSAMPLE x baud
//   rxd        in   asynchronous serial input, idle high
//   rx_data    out  last correctly framed byte (held until the next one)
//   rx_valid   out  one-cycle pulse, rx_data updated this cycle
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   busy       out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 tick_16x,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_prev;
    logic                 start_edge;

    logic [1:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // Synchroniser and edge-detect history reset to the idle (high) level so
    // that reset release on an idle line never looks like a start edge.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // Only a genuine falling edge starts a frame; a line that is merely low
    // (break, or still low after a framing error) is ignored.
    assign start_edge = rxd_prev & ~rxd_s;

    assign busy = (state != IDLE);

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (tick_16x) begin
                        if (tick_cnt == HALF_LAST) begin
                            if (!rxd_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                // Start bit gone by mid-bit: treat as a glitch.
                                state    <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick_16x) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + BW'(1);
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick_16x) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            // Leaving at mid stop bit lets a back-to-back
                            // start edge be caught with no idle gap.
                            state    <= IDLE;
                            if (rxd_s) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx: a table of single frames with hand-computed
// results, plus hand-written sequences for busy latency, back-to-back frames,
// start-bit glitch, framing error followed by a held-low line, reset in the
// middle of a frame, a tick freeze mid-frame and a continuous tick.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk_50M;
    logic       rst_n;
    logic       tick_16x;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS)
    ) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .tick_16x (tick_16x),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    // Tick generator, driven on the falling edge.
    logic tick_en;
    int   tick_div;
    int   div_cnt;

    initial begin
        tick_16x = 1'b0;
        div_cnt  = 0;
        forever begin
            @(negedge clk_50M);
            if (tick_en && div_cnt >= tick_div - 1) begin
                tick_16x = 1'b1;
                div_cnt  = 0;
            end else begin
                tick_16x = 1'b0;
                if (tick_en) div_cnt = div_cnt + 1;
            end
        end
    end

    // Output monitor.
    int         valid_cnt  = 0;
    int         ferr_cnt   = 0;
    int         busy_rise  = 0;
    int         bad_cnt    = 0;
    logic       pv = 1'b0, pf = 1'b0, pb = 1'b0;
    logic [7:0] vlog[$];

    always @(negedge clk_50M) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            vlog.push_back(rx_data);
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (busy && !pb) busy_rise <= busy_rise + 1;
        if ((rx_valid && frame_err) || (rx_valid && pv) || (frame_err && pf) ||
            ((rx_valid || frame_err) && busy))
            bad_cnt <= bad_cnt + 1;
        pv <= rx_valid;
        pf <= frame_err;
        pb <= busy;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Wait for n tick pulses; returns just after the posedge carrying the tick.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(posedge clk_50M);
                guard++;
            end while (!tick_16x && guard < 1000);
            if (!tick_16x) begin
                tests++;
                fails++;
                $display("FAIL tick_timeout: got no tick, expected one within 1000 clocks");
            end
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         dv;
        int         df;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[4];

    int v0, f0, b0, n0;
    logic [7:0] pattern;

    initial begin
        vecs[0] = '{data: 8'h5A, stop: 1'b1, dv: 1, df: 0, exp: 8'h5A};
        vecs[1] = '{data: 8'h01, stop: 1'b1, dv: 1, df: 0, exp: 8'h01};
        vecs[2] = '{data: 8'hC3, stop: 1'b0, dv: 0, df: 1, exp: 8'h01};
        vecs[3] = '{data: 8'h80, stop: 1'b1, dv: 1, df: 0, exp: 8'h80};

        rst_n    = 1'b0;
        rxd      = 1'b1;
        tick_en  = 1'b1;
        tick_div = 27;
        repeat (3) @(posedge clk_50M);
        #1;
        check("reset_rx_data",   rx_data,   8'h00);
        check("reset_rx_valid",  rx_valid,  1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy",      busy,      1'b0);
        rst_n = 1'b1;
        wait_ticks(4);

        // 0xA5 with busy latency from the line fall.
        v0 = valid_cnt; f0 = ferr_cnt;
        rxd = 1'b0;
        @(posedge clk_50M); #1;
        @(posedge clk_50M); #1;
        check("busy_lat_clk2", busy, 1'b0);
        @(posedge clk_50M); #1;
        check("busy_lat_clk3", busy, 1'b1);
        wait_ticks(OS);
        pattern = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(pattern[i]);
        send_bit(1'b1);
        check("a5_valid_cnt", valid_cnt - v0, 1);
        check("a5_ferr_cnt",  ferr_cnt - f0,  0);
        check("a5_rx_data",   rx_data,        8'hA5);
        check("a5_busy_done", busy,           1'b0);

        // Table of single frames.
        for (int k = 0; k < 4; k++) begin
            v0 = valid_cnt; f0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop);
            rxd = 1'b1;
            wait_ticks(4);
            check($sformatf("vec%0d_valid", k), valid_cnt - v0, vecs[k].dv);
            check($sformatf("vec%0d_ferr",  k), ferr_cnt - f0,  vecs[k].df);
            check($sformatf("vec%0d_data",  k), rx_data,        vecs[k].exp);
        end

        // Bad stop on 0x3C, line held low, then a clean 0x3C.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        check("ferr_pulse",    ferr_cnt - f0,  1);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_hold",     rx_data,        8'h80);
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise;
        wait_ticks(40);
        check("break_no_start", busy_rise - b0, 0);
        check("break_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        rxd = 1'b1;
        wait_ticks(OS);
        send_frame(8'h3C, 1'b1);
        check("after_break_valid", valid_cnt - v0, 1);
        check("after_break_data",  rx_data,        8'h3C);

        // Back-to-back frames with no idle bits.
        n0 = vlog.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(4);
        check("b2b_count", vlog.size() - n0, 2);
        if (vlog.size() >= n0 + 2) begin
            check("b2b_first",  vlog[n0],     8'h00);
            check("b2b_second", vlog[n0 + 1], 8'hFF);
        end

        // Start-bit glitch: low for 5 ticks, abandoned on the 8th.
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise;
        rxd = 1'b0;
        wait_ticks(5);
        rxd = 1'b1;
        wait_ticks(2);
        check("glitch_busy_t7", busy, 1'b1);
        wait_ticks(1);
        check("glitch_idle_t8", busy, 1'b0);
        wait_ticks(OS);
        check("glitch_busy_pulse", busy_rise - b0, 1);
        check("glitch_no_pulse",   (valid_cnt - v0) + (ferr_cnt - f0), 0);

        // Reset after data bit 4 of 0x81.
        pattern = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(pattern[i]);
        check("rst_mid_busy_before", busy, 1'b1);
        v0 = valid_cnt; f0 = ferr_cnt;
        rst_n = 1'b0;
        @(posedge clk_50M); #1;
        check("rst_mid_rx_data", rx_data,   8'h00);
        check("rst_mid_valid",   rx_valid,  1'b0);
        check("rst_mid_ferr",    frame_err, 1'b0);
        check("rst_mid_busy",    busy,      1'b0);
        rst_n = 1'b1;
        rxd   = 1'b1;
        wait_ticks(2 * OS);
        check("rst_mid_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h81, 1'b1);
        check("rst_after_valid", valid_cnt - v0, 1);
        check("rst_after_data",  rx_data,        8'h81);

        // Tick freeze for 100 clocks after data bit 3 of 0xB6.
        pattern = 8'hB6;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(pattern[i]);
        tick_en = 1'b0;
        repeat (100) @(posedge clk_50M);
        #1;
        check("freeze_busy",     busy, 1'b1);
        check("freeze_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        tick_en = 1'b1;
        for (int i = 4; i < 8; i++) send_bit(pattern[i]);
        send_bit(1'b1);
        check("freeze_valid", valid_cnt - v0, 1);
        check("freeze_data",  rx_data,        8'hB6);

        // Tick held high on every clock.
        tick_div = 1;
        v0 = valid_cnt;
        wait_ticks(1);
        send_frame(8'h69, 1'b1);
        wait_ticks(4);
        check("fast_valid", valid_cnt - v0, 1);
        check("fast_data",  rx_data,        8'h69);

        check("pulse_rules", bad_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
